word_decoder: RTL and testbench

- Downstream consumer of the two-word unpacker.
- Each cycle it takes up to two decoded code records (code, code_bak, dictionary index, literal payload) and rebuilds two 32-bit uncompressed words.
- Holds a 16-entry FIFO-replacement dictionary that is kept identical to the compressor's, including same-cycle first-to-second forwarding.
- Output is registered and feeds the decompressed-line assembler.

---
 rtl/word_decoder.sv | 97 +++++++++
 tb/tb_word_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/word_decoder.sv
// word_decoder: rebuilds two 32-bit words per cycle from code records using a 16-entry FIFO dictionary
module word_decoder #(
    parameter int DATA = 32,
    parameter int CODE = 2,
    parameter int WORD = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [CODE-1:0]         i_first_code,
    input  logic [CODE-1:0]         i_first_code_bak,
    input  logic [$clog2(WORD)-1:0] i_idx1,
    input  logic [DATA-1:0]         i_first_lit,
    input  logic [CODE-1:0]         i_second_code,
    input  logic [CODE-1:0]         i_second_code_bak,
    input  logic [$clog2(WORD)-1:0] i_idx2,
    input  logic [DATA-1:0]         i_second_lit,
    output logic                    o_valid,
    output logic [DATA-1:0]         o_word1,
    output logic [DATA-1:0]         o_word2,
    output logic [$clog2(WORD)-1:0] o_wr_ptr,
    output logic [7:0]              o_word_count
);
    localparam int IW = $clog2(WORD);

    logic [DATA-1:0] dict [WORD];
    logic [IW-1:0]   wr_ptr;
    logic [7:0]      count;
    logic [DATA-1:0] w1, w2, d2;
    logic            p1, p2;
    logic [IW-1:0]   slot2;

    // returns {push, word} for one record given its dictionary operand
    function automatic logic [DATA:0] decode(
        input logic [CODE-1:0] c,
        input logic [CODE-1:0] b,
        input logic [DATA-1:0] d,
        input logic [DATA-1:0] lit
    );
        case (c)
            2'b00:   decode = '0;
            2'b01:   decode = {1'b1, lit};
            2'b10:   decode = {1'b0, d};
            default: case (b)
                2'b00:   decode = {1'b1, d[DATA-1:16], lit[15:0]};
                2'b01:   decode = {1'b0, {(DATA-8){1'b0}}, lit[7:0]};
                2'b10:   decode = {1'b1, d[DATA-1:8], lit[7:0]};
                default: decode = '0;
            endcase
        endcase
    endfunction

    // decode both records; the second sees the first's push when it reads that slot
    always_comb begin
        {p1, w1} = decode(i_first_code, i_first_code_bak, dict[i_idx1], i_first_lit);
        d2 = (p1 && i_idx2 == wr_ptr) ? w1 : dict[i_idx2];
        {p2, w2} = decode(i_second_code, i_second_code_bak, d2, i_second_lit);
        slot2 = wr_ptr + IW'(p1);
    end

    // dictionary storage: first push at wr_ptr, second right after it
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset || i_clear) begin
            dict <= '{default: '0};
        end else if (i_valid) begin
            if (p1) dict[wr_ptr] <= w1;
            if (p2) dict[slot2] <= w2;
        end
    end

    // pointer, saturating word count and registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr  <= '0;
            count   <= '0;
            o_valid <= 1'b0;
            o_word1 <= '0;
            o_word2 <= '0;
        end else if (i_clear) begin
            wr_ptr  <= '0;
            count   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                wr_ptr  <= wr_ptr + IW'(p1) + IW'(p2);
                count   <= (count > 8'd253) ? 8'd255 : count + 8'd2;
                o_word1 <= w1;
                o_word2 <= w2;
            end
        end
    end

    assign o_wr_ptr     = wr_ptr;
    assign o_word_count = count;
endmodule

// File: tb/tb_word_decoder.sv
// tb_word_decoder: randomized self-checking bench with a record-by-record dictionary model
module tb_word_decoder;
    logic        i_clk, i_reset, i_clear, i_valid;
    logic [1:0]  i_first_code, i_first_code_bak, i_second_code, i_second_code_bak;
    logic [3:0]  i_idx1, i_idx2;
    logic [31:0] i_first_lit, i_second_lit;
    logic        o_valid;
    logic [31:0] o_word1, o_word2;
    logic [3:0]  o_wr_ptr;
    logic [7:0]  o_word_count;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mdict [16];
    int          mptr, mcnt;
    logic        ev;
    logic [31:0] ew1, ew2;
    int          eptr, ecnt;

    word_decoder dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid),
        .i_first_code(i_first_code), .i_first_code_bak(i_first_code_bak),
        .i_idx1(i_idx1), .i_first_lit(i_first_lit),
        .i_second_code(i_second_code), .i_second_code_bak(i_second_code_bak),
        .i_idx2(i_idx2), .i_second_lit(i_second_lit),
        .o_valid(o_valid), .o_word1(o_word1), .o_word2(o_word2),
        .o_wr_ptr(o_wr_ptr), .o_word_count(o_word_count)
    );

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference decode straight from the code table: {push, word}
    function automatic logic [32:0] ref_dec(input logic [1:0] c, b, input logic [31:0] d, lit);
        casez ({c, b})
            4'b00??: return {1'b0, 32'h0};
            4'b01??: return {1'b1, lit};
            4'b10??: return {1'b0, d};
            4'b1100: return {1'b1, d[31:16], lit[15:0]};
            4'b1101: return {1'b0, 24'h0, lit[7:0]};
            4'b1110: return {1'b1, d[31:8], lit[7:0]};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdict[i] = '0;
        mptr = 0; mcnt = 0;
        ev = 0; ew1 = 0; ew2 = 0; eptr = 0; ecnt = 0;
    endtask

    // compare process: every falling edge the outputs must match the model
    always @(negedge i_clk) begin
        check("o_valid", {31'h0, o_valid}, {31'h0, ev});
        check("o_word1", o_word1, ew1);
        check("o_word2", o_word2, ew2);
        check("o_wr_ptr", {28'h0, o_wr_ptr}, eptr);
        check("o_word_count", {24'h0, o_word_count}, ecnt);
    end

    // the reserved 11/11 code must never be presented
    always @(posedge i_clk)
        if (i_reset && i_valid && !i_clear)
            assert (!(i_first_code == 2'b11 && i_first_code_bak == 2'b11) &&
                    !(i_second_code == 2'b11 && i_second_code_bak == 2'b11))
            else $error("reserved code 11/11 presented");

    // drive one cycle, advance the model record by record, publish expectations after the edge
    task automatic cyc(input bit v, input bit clr,
                       input logic [1:0] c1, b1, input logic [3:0] x1, input logic [31:0] l1,
                       input logic [1:0] c2, b2, input logic [3:0] x2, input logic [31:0] l2);
        logic [1:0]  c[2], b[2];
        logic [3:0]  x[2];
        logic [31:0] l[2], w[2];
        logic [32:0] r;
        logic        nv;
        c = '{c1, c2}; b = '{b1, b2}; x = '{x1, x2}; l = '{l1, l2};
        i_valid = v; i_clear = clr;
        i_first_code = c1; i_first_code_bak = b1; i_idx1 = x1; i_first_lit = l1;
        i_second_code = c2; i_second_code_bak = b2; i_idx2 = x2; i_second_lit = l2;
        w = '{ew1, ew2};
        nv = 0;
        if (clr) begin
            for (int i = 0; i < 16; i++) mdict[i] = '0;
            mptr = 0; mcnt = 0;
        end else if (v) begin
            for (int k = 0; k < 2; k++) begin
                r = ref_dec(c[k], b[k], mdict[x[k]], l[k]);
                w[k] = r[31:0];
                if (r[32]) begin
                    mdict[mptr] = r[31:0];
                    mptr = (mptr + 1) % 16;
                end
            end
            mcnt = (mcnt + 2 > 255) ? 255 : mcnt + 2;
            nv = 1;
        end
        @(posedge i_clk);
        #1;
        ev = nv; ew1 = w[0]; ew2 = w[1]; eptr = mptr; ecnt = mcnt;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cyc(input bit allow_clear);
        logic [1:0] c1, b1, c2, b2;
        logic [3:0] x2;
        c1 = 2'($urandom_range(0, 3));
        b1 = 2'((c1 == 2'b11) ? $urandom_range(0, 2) : $urandom_range(0, 3));
        c2 = 2'($urandom_range(0, 3));
        b2 = 2'((c2 == 2'b11) ? $urandom_range(0, 2) : $urandom_range(0, 3));
        x2 = ($urandom_range(0, 2) == 0) ? 4'(mptr) : 4'($urandom_range(0, 15));
        cyc($urandom_range(0, 5) != 0, allow_clear && $urandom_range(0, 40) == 0,
            c1, b1, 4'($urandom_range(0, 15)), $urandom,
            c2, b2, x2, $urandom);
    endtask

    initial begin
        model_reset();
        i_reset = 0; i_clear = 0; i_valid = 0;
        i_first_code = 0; i_first_code_bak = 0; i_idx1 = 0; i_first_lit = 0;
        i_second_code = 0; i_second_code_bak = 0; i_idx2 = 0; i_second_lit = 0;
        repeat (2) @(posedge i_clk);
        #2;
        check("rst_word1", o_word1, 32'h0);
        check("rst_count", {24'h0, o_word_count}, 32'h0);
        i_reset = 1;

        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        check("zero_w1", o_word1, 32'h0);
        check("zero_count", {24'h0, o_word_count}, 32'd2);
        check("zero_valid", {31'h0, o_valid}, 32'd1);

        cyc(1, 0, 2'b01, 0, 0, 32'hDEADBEEF, 2'b10, 0, 0, 0);
        check("fwd_w1", o_word1, 32'hDEADBEEF);
        check("fwd_w2", o_word2, 32'hDEADBEEF);
        check("fwd_ptr", {28'h0, o_wr_ptr}, 32'd1);

        cyc(1, 0, 2'b11, 2'b00, 0, 32'h1234, 2'b11, 2'b10, 1, 32'h55);
        check("part_w1", o_word1, 32'hDEAD1234);
        check("part_w2", o_word2, 32'hDEAD1255);
        check("part_ptr", {28'h0, o_wr_ptr}, 32'd3);

        cyc(1, 0, 2'b11, 2'b01, 0, 32'hAB, 2'b00, 0, 0, 0);
        check("byte_w1", o_word1, 32'h000000AB);
        check("byte_ptr", {28'h0, o_wr_ptr}, 32'd3);

        idle();
        check("idle_hold", o_word1, 32'h000000AB);

        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            cyc(1, 0, 2'b01, 0, 0, 32'h1000_0000 + 32'(2 * k), 2'b01, 0, 0, 32'h1000_0001 + 32'(2 * k));
        check("wrap_ptr", {28'h0, o_wr_ptr}, 32'd0);
        cyc(1, 0, 2'b01, 0, 0, 32'h1700_0017, 2'b10, 0, 0, 0);
        check("wrap_17th", o_word2, 32'h1700_0017);

        cyc(1, 1, 2'b01, 0, 0, 32'h1, 2'b01, 0, 0, 32'h2);
        check("clr_valid", {31'h0, o_valid}, 32'd0);
        check("clr_ptr", {28'h0, o_wr_ptr}, 32'd0);
        check("clr_count", {24'h0, o_word_count}, 32'd0);
        cyc(1, 0, 2'b10, 0, 0, 0, 2'b10, 0, 7, 0);
        check("clr_dict0", o_word1, 32'h0);
        check("clr_dict7", o_word2, 32'h0);

        for (int k = 0; k < 130; k++) begin
            rand_cyc(0);
            if (!i_valid) k--;
        end
        check("sat_count", {24'h0, o_word_count}, 32'd255);

        for (int k = 0; k < 300; k++) rand_cyc(1);

        cyc(1, 0, 2'b01, 0, 0, 32'hCAFEF00D, 2'b01, 0, 0, 32'h0BADBEEF);
        i_reset = 0;
        #1;
        check("arst_valid", {31'h0, o_valid}, 32'd0);
        check("arst_w1", o_word1, 32'h0);
        check("arst_w2", o_word2, 32'h0);
        check("arst_ptr", {28'h0, o_wr_ptr}, 32'd0);
        check("arst_count", {24'h0, o_word_count}, 32'd0);
        model_reset();
        i_valid = 0;
        @(posedge i_clk);
        #2;
        i_reset = 1;
        cyc(1, 0, 2'b10, 0, 3, 0, 2'b10, 0, 15, 0);
        check("arst_dict", o_word1 | o_word2, 32'h0);
        for (int k = 0; k < 50; k++) rand_cyc(1);

        @(posedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
